vme_mem_sequencer: RTL and testbench

Upstream master for the Cheby-generated register blocks that use the VMERdMem/VMEWrMem memory-strobe interface. It accepts single-word host transactions on a simple req/busy interface. For each transaction it issues one single-cycle read or write strobe toward the register block and waits for the matching VMERdDone or VMEWrDone. It then returns the read data and a success acknowledge, or an error pulse if no done arrives within a bounded timeout. Exactly one transaction is outstanding at any time.

---
 rtl/vme_mem_seq_pkg.sv | 23 ++
 rtl/vme_mem_sequencer.sv | 111 +++++++++++
 tb/tb_vme_mem_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_mem_seq_pkg.sv
// Shared types and sizing helpers for the VME memory-strobe sequencer.
package vme_mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Smallest width that can hold the value TIMEOUT, i.e. ceil(log2(TIMEOUT+1)).
  function automatic int cnt_width(input int timeout);
    int w;
    w = 31;
    for (int i = 31; i >= 1; i--) begin
      if ((64'd1 << i) >= 64'(timeout) + 64'd1) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/vme_mem_sequencer.sv
// Single-outstanding host master driving a VMERdMem/VMEWrMem register block,
// with a bounded wait for the matching done and a one-cycle ack/err response.
//
// state  | meaning
// IDLE   | no transaction; HostReq accepted here only
// STROBE | one-cycle read or write strobe on the target
// WAIT   | counting cycles until the matching done or timeout
// RESP   | one-cycle HostAck or HostErr, then back to IDLE
module vme_mem_sequencer
  import vme_mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  HostReq,
  input  logic                  HostWr,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  input  logic [31:0]           HostWrData,
  output logic                  HostBusy,
  output logic                  HostAck,
  output logic                  HostErr,
  output logic [31:0]           HostRdData,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [31:0]           VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  input  logic [31:0]           VMERdData
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  seq_state_t    state;
  logic          wr_flag;
  logic [CW-1:0] cnt;
  logic          done_ok;

  // Only the done matching the latched direction counts; the other is ignored.
  assign done_ok = wr_flag ? VMEWrDone : VMERdDone;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      wr_flag    <= 1'b0;
      cnt        <= '0;
      HostBusy   <= 1'b0;
      HostAck    <= 1'b0;
      HostErr    <= 1'b0;
      HostRdData <= '0;
      VMEAddr    <= '0;
      VMEWrData  <= '0;
      VMERdMem   <= 1'b0;
      VMEWrMem   <= 1'b0;
    end else begin
      HostAck  <= 1'b0;
      HostErr  <= 1'b0;
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      case (state)
        IDLE: begin
          if (HostReq) begin
            VMEAddr   <= HostAddr;
            VMEWrData <= HostWrData;
            wr_flag   <= HostWr;
            HostBusy  <= 1'b1;
            VMERdMem  <= ~HostWr;
            VMEWrMem  <= HostWr;
            state     <= STROBE;
          end
        end
        STROBE: begin
          if (done_ok) begin
            HostAck <= 1'b1;
            if (!wr_flag) HostRdData <= VMERdData;
            state <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A done on the last counted cycle still wins over the timeout.
          if (done_ok) begin
            HostAck <= 1'b1;
            if (!wr_flag) HostRdData <= VMERdData;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            HostErr <= 1'b1;
            state   <= RESP;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          HostBusy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          HostBusy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_mem_sequencer.sv
// Directed bench: one instance with TIMEOUT=8 and one with TIMEOUT=4 share stimulus.
module tb_vme_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_wr;
  logic [13:0] host_addr;
  logic [31:0] host_wr_data;
  logic        rd_done, wr_done;
  logic [31:0] rd_data;

  logic        busy8, ack8, err8, rdm8, wrm8;
  logic [31:0] hrd8, vwd8;
  logic [13:0] vaddr8;
  logic        busy4, ack4, err4, rdm4, wrm4;
  logic [31:0] hrd4, vwd4;
  logic [13:0] vaddr4;

  int checks = 0;
  int failures = 0;
  int rd_strobes = 0;
  int wr_strobes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdm8) rd_strobes <= rd_strobes + 1;
    if (wrm8) wr_strobes <= wr_strobes + 1;
  end

  vme_mem_sequencer #(.ADDR_WIDTH(14), .TIMEOUT(8)) dut8 (
    .Clk(clk), .RstN(rst_n), .HostReq(host_req), .HostWr(host_wr),
    .HostAddr(host_addr), .HostWrData(host_wr_data), .HostBusy(busy8),
    .HostAck(ack8), .HostErr(err8), .HostRdData(hrd8), .VMEAddr(vaddr8),
    .VMEWrData(vwd8), .VMERdMem(rdm8), .VMEWrMem(wrm8),
    .VMERdDone(rd_done), .VMEWrDone(wr_done), .VMERdData(rd_data)
  );

  vme_mem_sequencer #(.ADDR_WIDTH(14), .TIMEOUT(4)) dut4 (
    .Clk(clk), .RstN(rst_n), .HostReq(host_req), .HostWr(host_wr),
    .HostAddr(host_addr), .HostWrData(host_wr_data), .HostBusy(busy4),
    .HostAck(ack4), .HostErr(err4), .HostRdData(hrd4), .VMEAddr(vaddr4),
    .VMEWrData(vwd4), .VMERdMem(rdm4), .VMEWrMem(wrm4),
    .VMERdDone(rd_done), .VMEWrDone(wr_done), .VMERdData(rd_data)
  );

  task automatic nclk(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wr_data = '0;
    rd_done = 1'b0; wr_done = 1'b0; rd_data = '0;
    nclk(2);
    checks++;
    if ({busy8, ack8, err8, rdm8, wrm8, hrd8, vaddr8, vwd8} !== '0) begin
      failures++;
      $display("FAIL reset_dut8: got busy=%0b ack=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h wdata=%h want all 0",
               busy8, ack8, err8, rdm8, wrm8, hrd8, vaddr8, vwd8);
    end
    checks++;
    if ({busy4, ack4, err4, rdm4, wrm4, hrd4, vaddr4, vwd4} !== '0) begin
      failures++;
      $display("FAIL reset_dut4: got busy=%0b ack=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h wdata=%h want all 0",
               busy4, ack4, err4, rdm4, wrm4, hrd4, vaddr4, vwd4);
    end
    rst_n = 1'b1;
    nclk(1);
  endtask

  task automatic test_read();
    int rs0;
    rs0 = rd_strobes;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 14'h0123;
    nclk(1);
    host_req = 1'b0;
    checks++;
    if ({rdm8, wrm8, busy8, vaddr8} !== {1'b1, 1'b0, 1'b1, 14'h0123}) begin
      failures++;
      $display("FAIL read_strobe: got rd=%0b wr=%0b busy=%0b addr=%h want 1 0 1 0123", rdm8, wrm8, busy8, vaddr8);
    end
    nclk(1);
    checks++;
    if ({rdm8, ack8} !== 2'b00) begin
      failures++;
      $display("FAIL read_strobe_len: got rd=%0b ack=%0b want 0 0", rdm8, ack8);
    end
    rd_done = 1'b1; rd_data = 32'h0000_2A05;
    nclk(1);
    rd_done = 1'b0; rd_data = 32'hDEAD_BEEF;
    checks++;
    if ({ack8, err8, hrd8} !== {1'b1, 1'b0, 32'h0000_2A05}) begin
      failures++;
      $display("FAIL read_ack: got ack=%0b err=%0b rdata=%h want 1 0 00002a05", ack8, err8, hrd8);
    end
    nclk(1);
    checks++;
    if ({ack8, busy8, hrd8} !== {1'b0, 1'b0, 32'h0000_2A05} || rd_strobes - rs0 != 1) begin
      failures++;
      $display("FAIL read_end: got ack=%0b busy=%0b rdata=%h strobes=%0d want 0 0 00002a05 1",
               ack8, busy8, hrd8, rd_strobes - rs0);
    end
  endtask

  task automatic test_write();
    host_req = 1'b1; host_wr = 1'b1; host_addr = 14'h0004; host_wr_data = 32'h0000_3FFF;
    nclk(1);
    host_req = 1'b0; host_addr = 14'h3FFF; host_wr_data = '0;
    checks++;
    if ({wrm8, rdm8, vaddr8, vwd8} !== {1'b1, 1'b0, 14'h0004, 32'h0000_3FFF}) begin
      failures++;
      $display("FAIL write_strobe: got wr=%0b rd=%0b addr=%h wdata=%h want 1 0 0004 00003fff", wrm8, rdm8, vaddr8, vwd8);
    end
    nclk(2);
    checks++;
    if ({wrm8, ack8} !== 2'b00) begin
      failures++;
      $display("FAIL write_early: got wr=%0b ack=%0b want 0 0", wrm8, ack8);
    end
    wr_done = 1'b1;
    nclk(1);
    wr_done = 1'b0;
    checks++;
    if ({ack8, err8, vaddr8, vwd8, hrd8} !== {1'b1, 1'b0, 14'h0004, 32'h0000_3FFF, 32'h0000_2A05}) begin
      failures++;
      $display("FAIL write_ack: got ack=%0b err=%0b addr=%h wdata=%h rdata=%h want 1 0 0004 00003fff 00002a05",
               ack8, err8, vaddr8, vwd8, hrd8);
    end
    nclk(1);
    checks++;
    if ({ack8, busy8} !== 2'b00) begin
      failures++;
      $display("FAIL write_end: got ack=%0b busy=%0b want 0 0", ack8, busy8);
    end
  endtask

  task automatic test_timeout();
    int rs0;
    logic exp8, exp4;
    rs0 = rd_strobes;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 14'h0010;
    nclk(1);
    host_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      nclk(1);
      exp8 = (k == 9);
      exp4 = (k == 5);
      checks++;
      if ({err8, ack8, err4, ack4} !== {exp8, 1'b0, exp4, 1'b0}) begin
        failures++;
        $display("FAIL timeout_cycle%0d: got err8=%0b ack8=%0b err4=%0b ack4=%0b want %0b 0 %0b 0",
                 k, err8, ack8, err4, ack4, exp8, exp4);
      end
    end
    checks++;
    if ({busy8, hrd8} !== {1'b0, 32'h0000_2A05}) begin
      failures++;
      $display("FAIL timeout_end: got busy=%0b rdata=%h want 0 00002a05", busy8, hrd8);
    end
    nclk(1);
    rd_done = 1'b1; rd_data = 32'h0000_5555;
    nclk(1);
    rd_done = 1'b0;
    nclk(1);
    checks++;
    if ({ack8, err8, busy8, hrd8} !== {3'b000, 32'h0000_2A05} || rd_strobes - rs0 != 1) begin
      failures++;
      $display("FAIL late_done: got ack=%0b err=%0b busy=%0b rdata=%h strobes=%0d want 0 0 0 00002a05 1",
               ack8, err8, busy8, hrd8, rd_strobes - rs0);
    end
  endtask

  task automatic test_coincident();
    host_req = 1'b1; host_wr = 1'b0; host_addr = 14'h0020;
    nclk(1);
    host_req = 1'b0;
    nclk(4);
    checks++;
    if ({ack4, err4, busy4} !== 3'b001) begin
      failures++;
      $display("FAIL coinc_pre: got ack=%0b err=%0b busy=%0b want 0 0 1", ack4, err4, busy4);
    end
    rd_done = 1'b1; rd_data = 32'h0000_4C4C;
    nclk(1);
    rd_done = 1'b0;
    checks++;
    if ({ack4, err4, hrd4} !== {1'b1, 1'b0, 32'h0000_4C4C}) begin
      failures++;
      $display("FAIL coinc_ack: got ack=%0b err=%0b rdata=%h want 1 0 00004c4c", ack4, err4, hrd4);
    end
    nclk(2);
  endtask

  task automatic test_wrong_type();
    int rs0, ws0;
    rs0 = rd_strobes; ws0 = wr_strobes;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 14'h0030;
    nclk(1);
    host_wr = 1'b1; host_addr = 14'h0031;
    nclk(1);
    wr_done = 1'b1;
    nclk(1);
    wr_done = 1'b0;
    checks++;
    if ({ack8, err8, busy8} !== 3'b001) begin
      failures++;
      $display("FAIL wrong_done: got ack=%0b err=%0b busy=%0b want 0 0 1", ack8, err8, busy8);
    end
    nclk(2);
    rd_done = 1'b1; rd_data = 32'h0BAD_F00D;
    nclk(1);
    rd_done = 1'b0; host_req = 1'b0;
    checks++;
    if ({ack8, err8, hrd8, vaddr8} !== {1'b1, 1'b0, 32'h0BAD_F00D, 14'h0030}) begin
      failures++;
      $display("FAIL wrong_ack: got ack=%0b err=%0b rdata=%h addr=%h want 1 0 0badf00d 0030", ack8, err8, hrd8, vaddr8);
    end
    nclk(2);
    checks++;
    if (busy8 !== 1'b0 || rd_strobes - rs0 != 1 || wr_strobes - ws0 != 0) begin
      failures++;
      $display("FAIL busy_drop: got busy=%0b rd_strobes=%0d wr_strobes=%0d want 0 1 0",
               busy8, rd_strobes - rs0, wr_strobes - ws0);
    end
  endtask

  task automatic test_reset_mid();
    int rs0;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 14'h00AA; host_wr_data = 32'h0000_1111;
    nclk(1);
    host_req = 1'b0;
    nclk(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, ack8, err8, rdm8, wrm8, hrd8, vaddr8, vwd8} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%0b ack=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h wdata=%h want all 0",
               busy8, ack8, err8, rdm8, wrm8, hrd8, vaddr8, vwd8);
    end
    nclk(1);
    rst_n = 1'b1;
    nclk(1);
    rs0 = rd_strobes;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 14'h0155;
    nclk(1);
    host_req = 1'b0;
    checks++;
    if ({rdm8, busy8, vaddr8} !== {1'b1, 1'b1, 14'h0155}) begin
      failures++;
      $display("FAIL post_reset_strobe: got rd=%0b busy=%0b addr=%h want 1 1 0155", rdm8, busy8, vaddr8);
    end
    nclk(1);
    rd_done = 1'b1; rd_data = 32'h1234_5678;
    nclk(1);
    rd_done = 1'b0;
    checks++;
    if ({ack8, err8, hrd8} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      failures++;
      $display("FAIL post_reset_ack: got ack=%0b err=%0b rdata=%h want 1 0 12345678", ack8, err8, hrd8);
    end
    nclk(1);
    checks++;
    if (busy8 !== 1'b0 || rd_strobes - rs0 != 1) begin
      failures++;
      $display("FAIL post_reset_end: got busy=%0b strobes=%0d want 0 1", busy8, rd_strobes - rs0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_coincident();
    test_wrong_type();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
